// File: rtl/adc_decim_avg.sv
// Dual-channel boxcar decimator: averages 2^L valid A/B sample pairs and
// emits one averaged pair per window with a single-cycle strobe.
module adc_decim_avg #(
  parameter int DATA_SZ  = 14,
  parameter int LOG2_MAX = 10
) (
  input  logic                      adc_clk_i,
  input  logic                      adc_rst_i,
  input  logic [3:0]                decim_log2_i,
  input  logic                      sync_i,
  input  logic                      data_a_en_i,
  input  logic signed [DATA_SZ-1:0] data_a_i,
  input  logic                      data_b_en_i,
  input  logic signed [DATA_SZ-1:0] data_b_i,
  output logic                      data_en_o,
  output logic signed [DATA_SZ-1:0] data_a_o,
  output logic signed [DATA_SZ-1:0] data_b_o,
  output logic [LOG2_MAX:0]         win_cnt_o
);

  localparam int         ACC_W = DATA_SZ + LOG2_MAX;
  localparam int         CNT_W = LOG2_MAX + 1;
  localparam logic [3:0] L_MAX = 4'(LOG2_MAX);

  logic signed [ACC_W-1:0]   acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic signed [ACC_W-1:0]   base_a, base_b, sum_a, sum_b;
  logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_base, cnt_term;
  logic [3:0]                l_act_q, l_act_d, l_clamp, l_eff;
  logic                      en_q, en_d;
  logic signed [DATA_SZ-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic                      smp, first, last;

  always_comb begin
    smp      = data_a_en_i & data_b_en_i;
    l_clamp  = (decim_log2_i > L_MAX) ? L_MAX : decim_log2_i;
    // sync restarts the window in the same cycle, so a coincident sample is sample 1
    cnt_base = sync_i ? '0 : cnt_q;
    first    = (cnt_base == '0);
    l_eff    = first ? l_clamp : l_act_q;
    cnt_term = (CNT_W'(1) << l_eff) - CNT_W'(1);
    last     = smp & (cnt_base == cnt_term);

    base_a   = first ? '0 : acc_a_q;
    base_b   = first ? '0 : acc_b_q;
    sum_a    = base_a + {{LOG2_MAX{data_a_i[DATA_SZ-1]}}, data_a_i};
    sum_b    = base_b + {{LOG2_MAX{data_b_i[DATA_SZ-1]}}, data_b_i};

    acc_a_d  = acc_a_q;
    acc_b_d  = acc_b_q;
    cnt_d    = cnt_base;
    l_act_d  = l_act_q;
    en_d     = 1'b0;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;

    if (smp) begin
      l_act_d = l_eff;
      acc_a_d = sum_a;
      acc_b_d = sum_b;
      if (last) begin
        cnt_d   = '0;
        en_d    = 1'b1;
        out_a_d = DATA_SZ'(sum_a >>> l_eff);
        out_b_d = DATA_SZ'(sum_b >>> l_eff);
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_q   <= '0;
      l_act_q <= '0;
      en_q    <= 1'b0;
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_q   <= cnt_d;
      l_act_q <= l_act_d;
      en_q    <= en_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
    end
  end

  assign data_en_o = en_q;
  assign data_a_o  = out_a_q;
  assign data_b_o  = out_b_q;
  assign win_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_decim_avg.sv
// Self-checking bench for adc_decim_avg against a queue-based window model.
module tb_adc_decim_avg;

  logic               adc_clk_i = 1'b0;
  logic               adc_rst_i;
  logic [3:0]         decim_log2_i;
  logic               sync_i;
  logic               data_a_en_i, data_b_en_i;
  logic signed [13:0] data_a_i, data_b_i;
  logic               data_en_o;
  logic signed [13:0] data_a_o, data_b_o;
  logic [10:0]        win_cnt_o;

  adc_decim_avg #(.DATA_SZ(14), .LOG2_MAX(10)) dut (
    .adc_clk_i   (adc_clk_i),
    .adc_rst_i   (adc_rst_i),
    .decim_log2_i(decim_log2_i),
    .sync_i      (sync_i),
    .data_a_en_i (data_a_en_i),
    .data_a_i    (data_a_i),
    .data_b_en_i (data_b_en_i),
    .data_b_i    (data_b_i),
    .data_en_o   (data_en_o),
    .data_a_o    (data_a_o),
    .data_b_o    (data_b_o),
    .win_cnt_o   (win_cnt_o)
  );

  always #5 adc_clk_i = ~adc_clk_i;

  int checks = 0;
  int errors = 0;

  // reference model: samples of the open window, held as plain integers
  int                 qa[$], qb[$];
  int                 m_l = 0;
  logic               exp_en = 1'b0;
  logic signed [13:0] exp_a = '0, exp_b = '0;
  logic [10:0]        exp_cnt = '0;

  function automatic longint favg(input int q[$], input int l);
    longint s = 0;
    longint d = longint'(1) << l;
    longint r;
    foreach (q[i]) s += q[i];
    r = s / d;
    if ((s % d) != 0 && s < 0) r = r - 1;  // floor, not truncate toward zero
    return r;
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  // drive one cycle, advance the model, return #1 after the edge
  task automatic cycle(input bit rst, input bit ea, input bit eb, input int a,
                       input int b, input bit sy, input int l);
    adc_rst_i    = rst;
    data_a_en_i  = ea;
    data_b_en_i  = eb;
    data_a_i     = 14'(a);
    data_b_i     = 14'(b);
    sync_i       = sy;
    decim_log2_i = 4'(l);
    exp_en = 1'b0;
    if (rst) begin
      qa.delete(); qb.delete();
      exp_a = '0; exp_b = '0;
    end else begin
      if (sy) begin qa.delete(); qb.delete(); end
      if (ea && eb) begin
        if (qa.size() == 0) m_l = (l > 10) ? 10 : l;
        qa.push_back(a);
        qb.push_back(b);
        if (qa.size() == (1 << m_l)) begin
          exp_a  = 14'(favg(qa, m_l));
          exp_b  = 14'(favg(qb, m_l));
          exp_en = 1'b1;
          qa.delete(); qb.delete();
        end
      end
    end
    exp_cnt = 11'(qa.size());
    @(posedge adc_clk_i);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 1234, -777, 0, 0);
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== 40'd0) begin
        errors++;
        $display("FAIL reset_zero c%0d: en=%0b a=%0d b=%0d cnt=%0d want all 0", i, data_en_o, data_a_o, data_b_o, win_cnt_o);
      end
      checks++;
    end
    // partial window cut by reset must not produce a strobe
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, 2);
    cycle(1, 1, 1, 55, 66, 0, 2);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, 2);
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
        errors++;
        $display("FAIL reset_after c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
      end
      checks++;
      if (data_en_o !== (i == 3)) begin
        errors++;
        $display("FAIL reset_strobe c%0d: en=%0b want %0b", i, data_en_o, (i == 3));
      end
      checks++;
    end
  endtask

  task automatic test_l0();
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 1, -5, 7, 0, 0);
    if (data_en_o !== 1'b1 || data_a_o !== -14'sd5 || data_b_o !== 14'sd7) begin
      errors++;
      $display("FAIL l0_fixed: en=%0b a=%0d b=%0d want en=1 a=-5 b=7", data_en_o, data_a_o, data_b_o);
    end
    checks++;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, 0);
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt} || data_en_o !== 1'b1) begin
        errors++;
        $display("FAIL l0_stream c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=1 a=%0d b=%0d cnt=%0d", i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_a, exp_b, exp_cnt);
      end
      checks++;
    end
  endtask

  task automatic test_l2();
    int va[4] = '{100, 200, 300, 401};
    int vb[4] = '{-1, -2, -2, -2};
    for (int pass = 0; pass < 2; pass++) begin
      int strobes = 0;
      cycle(0, 0, 0, 0, 0, 1, 2);
      for (int k = 0; k < 4; k++) begin
        // second pass inserts idle cycles, some with only one channel valid
        if (pass == 1) begin
          cycle(0, 1, 0, 999, 999, 0, 2);
          cycle(0, 0, 1, -999, -999, 0, 2);
          if (data_en_o !== 1'b0 || win_cnt_o !== 11'(k)) begin
            errors++;
            $display("FAIL l2_idle p%0d k%0d: en=%0b cnt=%0d want en=0 cnt=%0d", pass, k, data_en_o, win_cnt_o, k);
          end
          checks++;
        end
        cycle(0, 1, 1, va[k], vb[k], 0, 2);
        if (data_en_o) strobes++;
      end
      if (data_en_o !== 1'b1 || data_a_o !== 14'sd250 || data_b_o !== -14'sd2 || win_cnt_o !== 11'd0) begin
        errors++;
        $display("FAIL l2_fixed p%0d: en=%0b a=%0d b=%0d cnt=%0d want en=1 a=250 b=-2 cnt=0", pass, data_en_o, data_a_o, data_b_o, win_cnt_o);
      end
      checks++;
      cycle(0, 0, 0, 0, 0, 0, 2);
      if (data_en_o) strobes++;
      if (strobes != 1 || data_a_o !== 14'sd250) begin
        errors++;
        $display("FAIL l2_once p%0d: strobes=%0d a=%0d want strobes=1 a=250", pass, strobes, data_a_o);
      end
      checks++;
    end
  endtask

  task automatic test_full_scale();
    int v[2] = '{8191, -8192};
    for (int p = 0; p < 2; p++) begin
      int strobes = 0;
      cycle(0, 0, 0, 0, 0, 1, 10);
      for (int i = 0; i < 1024; i++) begin
        cycle(0, 1, 1, v[p], v[p], 0, 10);
        if (data_en_o) strobes++;
        if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
          errors++;
          $display("FAIL full_scale p%0d c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", p, i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
        end
        checks++;
      end
      if (strobes != 1 || data_a_o !== 14'(v[p]) || data_b_o !== 14'(v[p])) begin
        errors++;
        $display("FAIL full_scale_end p%0d: strobes=%0d a=%0d b=%0d want strobes=1 a=b=%0d", p, strobes, data_a_o, data_b_o, v[p]);
      end
      checks++;
    end
  endtask

  task automatic test_sync();
    cycle(0, 0, 0, 0, 0, 1, 2);
    cycle(0, 1, 1, 4000, 4000, 0, 2);
    cycle(0, 1, 1, 4000, 4000, 0, 2);
    cycle(0, 0, 0, 0, 0, 1, 2);
    if (win_cnt_o !== 11'd0 || data_en_o !== 1'b0) begin
      errors++;
      $display("FAIL sync_clear: en=%0b cnt=%0d want en=0 cnt=0", data_en_o, win_cnt_o);
    end
    checks++;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 8 * i, -8 * i, 0, 2);
    if (data_en_o !== 1'b1 || data_a_o !== 14'sd12 || data_b_o !== -14'sd12) begin
      errors++;
      $display("FAIL sync_next: en=%0b a=%0d b=%0d want en=1 a=12 b=-12", data_en_o, data_a_o, data_b_o);
    end
    checks++;
    // sync coincident with what would be the window's final sample
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, 2);
    cycle(0, 1, 1, 40, 80, 1, 2);
    if (data_en_o !== 1'b0 || win_cnt_o !== 11'd1) begin
      errors++;
      $display("FAIL sync_coincide: en=%0b cnt=%0d want en=0 cnt=1", data_en_o, win_cnt_o);
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, 2);
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
        errors++;
        $display("FAIL sync_tail c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
      end
      checks++;
    end
    if (data_en_o !== 1'b1) begin
      errors++;
      $display("FAIL sync_tail_strobe: en=%0b want 1", data_en_o);
    end
    checks++;
  endtask

  task automatic test_l_change();
    cycle(0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 1, rnd_smp(), rnd_smp(), 0, (i == 0) ? 2 : 3);
      if (data_en_o !== (i == 3 || i == 11)) begin
        errors++;
        $display("FAIL l_change_strobe c%0d: en=%0b want %0b", i, data_en_o, (i == 3 || i == 11));
      end
      checks++;
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
        errors++;
        $display("FAIL l_change c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
      end
      checks++;
    end
  endtask

  task automatic test_clamp();
    int n = 0;
    int strobes = 0;
    int guard = 0;
    cycle(0, 0, 0, 0, 0, 1, 15);
    while (n < 1024 && guard < 4000) begin
      bit s = ($urandom_range(3) != 0);
      cycle(0, s, s, rnd_smp(), rnd_smp(), 0, 15);
      guard++;
      if (s) n++;
      if (data_en_o) strobes++;
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
        errors++;
        $display("FAIL clamp n%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", n, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
      end
      checks++;
    end
    if (strobes != 1 || data_en_o !== 1'b1 || n != 1024) begin
      errors++;
      $display("FAIL clamp_period: strobes=%0d en=%0b samples=%0d want strobes=1 en=1 samples=1024", strobes, data_en_o, n);
    end
    checks++;
  endtask

  task automatic test_random();
    int l = 1;
    for (int i = 0; i < 3000; i++) begin
      bit rst = ($urandom_range(399) == 0);
      bit sy  = ($urandom_range(39) == 0);
      if ($urandom_range(29) == 0) l = ($urandom_range(7) == 0) ? 15 : int'($urandom_range(4));
      cycle(rst, $urandom_range(4) != 0, $urandom_range(4) != 0, rnd_smp(), rnd_smp(), sy, l);
      if ({data_en_o, data_a_o, data_b_o, win_cnt_o} !== {exp_en, exp_a, exp_b, exp_cnt}) begin
        errors++;
        $display("FAIL random c%0d: en=%0b a=%0d b=%0d cnt=%0d want en=%0b a=%0d b=%0d cnt=%0d", i, data_en_o, data_a_o, data_b_o, win_cnt_o, exp_en, exp_a, exp_b, exp_cnt);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_l0();
    test_l2();
    test_full_scale();
    test_sync();
    test_l_change();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
